csr_access_unit: RTL and testbench

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit_pkg.sv | 24 ++
 rtl/csr_access_unit_if.sv | 38 +++
 rtl/csr_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_csr_access_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: bus widths, op encoding and
// controller state encoding.
package csr_access_unit_pkg;

  localparam int CSR_ADDR_W = 12;
  localparam int CSR_DATA_W = 32;

  // CSR instruction flavours as presented on cmdOp
  typedef enum logic [1:0] {
    CSR_OP_RESERVED = 2'b00,
    CSR_OP_RW       = 2'b01,
    CSR_OP_RS       = 2'b10,
    CSR_OP_RC       = 2'b11
  } csr_op_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } csr_state_e;

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundles the core-side command/result handshake and the CSR bus.
// slave  = the access unit's view, master = core + responders' view.
interface csr_access_unit_if;
  import csr_access_unit_pkg::*;

  logic                  cmdValid;
  logic                  cmdReady;
  logic [1:0]            cmdOp;
  logic [CSR_ADDR_W-1:0] cmdAddress;
  logic [CSR_DATA_W-1:0] cmdOperand;
  logic                  cmdWriteSuppress;
  logic                  cmdFlush;
  logic                  resultValid;
  logic [CSR_DATA_W-1:0] resultData;
  logic                  resultIllegal;
  logic                  csrReadEnable;
  logic                  csrWriteEnable;
  logic [CSR_ADDR_W-1:0] csrReadAddress;
  logic [CSR_ADDR_W-1:0] csrWriteAddress;
  logic [CSR_DATA_W-1:0] csrWriteData;
  logic [CSR_DATA_W-1:0] csrReadData;
  logic                  csrRequestOutput;

  modport slave (
    input  cmdValid, cmdOp, cmdAddress, cmdOperand, cmdWriteSuppress, cmdFlush,
           csrReadData, csrRequestOutput,
    output cmdReady, resultValid, resultData, resultIllegal,
           csrReadEnable, csrWriteEnable, csrReadAddress, csrWriteAddress, csrWriteData
  );

  modport master (
    output cmdValid, cmdOp, cmdAddress, cmdOperand, cmdWriteSuppress, cmdFlush,
           csrReadData, csrRequestOutput,
    input  cmdReady, resultValid, resultData, resultIllegal,
           csrReadEnable, csrWriteEnable, csrReadAddress, csrWriteAddress, csrWriteData
  );

endinterface

// File: rtl/csr_access_unit.sv
// CSR access unit: sequences a CSR instruction as read -> optional
// read-modify-write -> completion pulse. All outputs are registered and
// derived from the next state, so they line up with the state they belong to.
// Optional feature macro: CSR_READONLY_CHECK_EN (address-based read-only
// fault for addresses with [11:10] == 2'b11 when a write is wanted).
module csr_access_unit
  import csr_access_unit_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  csr_access_unit_if.slave bus
);

  csr_state_e            state_q, state_d;
  csr_op_e               op_q, op_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [CSR_DATA_W-1:0] operand_q, operand_d;
  logic                  suppress_q, suppress_d;
  logic [CSR_DATA_W-1:0] old_q, old_d;
  logic                  illegal_q, illegal_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  result_valid_q, result_valid_d;
  logic [CSR_DATA_W-1:0] result_data_q, result_data_d;
  logic                  result_illegal_q, result_illegal_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [CSR_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CSR_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CSR_DATA_W-1:0] wr_data_q, wr_data_d;

  logic                  write_wanted_s;
  logic                  ro_fault_s;
  logic [CSR_DATA_W-1:0] new_value_s;

  // Value written back for each op, given the value just read
  function automatic logic [CSR_DATA_W-1:0] csr_new_value(
    input csr_op_e               op,
    input logic [CSR_DATA_W-1:0] old_val,
    input logic [CSR_DATA_W-1:0] operand
  );
    logic [CSR_DATA_W-1:0] res;
    case (op)
      CSR_OP_RW: res = operand;
      CSR_OP_RS: res = old_val | operand;
      CSR_OP_RC: res = old_val & ~operand;
      default:   res = {CSR_DATA_W{1'b0}};
    endcase
    return res;
  endfunction

  // RW always writes; RS/RC write only when the operand source is not x0/imm 0
  assign write_wanted_s = (op_q == CSR_OP_RW) || !suppress_q;
  // The write data is formed from the live read data while in READ
  assign new_value_s    = csr_new_value(op_q, bus.csrReadData, operand_q);

`ifdef CSR_READONLY_CHECK_EN
  assign ro_fault_s = (addr_q[11:10] == 2'b11) && write_wanted_s;
`else
  assign ro_fault_s = 1'b0;
`endif

  // Next-state and latched-request logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    operand_d  = operand_q;
    suppress_d = suppress_q;
    old_d      = old_q;
    illegal_d  = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmdValid) begin
          op_d       = csr_op_e'(bus.cmdOp);
          addr_d     = bus.cmdAddress;
          operand_d  = bus.cmdOperand;
          suppress_d = bus.cmdWriteSuppress;
          old_d      = {CSR_DATA_W{1'b0}};
          if (bus.cmdOp == CSR_OP_RESERVED) begin
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            illegal_d = 1'b0;
            state_d   = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus.cmdFlush) begin
          state_d = ST_IDLE;
        end else begin
          old_d = bus.csrReadData;
          if (!bus.csrRequestOutput || ro_fault_s) begin
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end else if (write_wanted_s) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs computed from the state being entered
  always_comb begin
    cmd_ready_d      = 1'b0;
    result_valid_d   = 1'b0;
    result_illegal_d = 1'b0;
    result_data_d    = {CSR_DATA_W{1'b0}};
    rd_en_d          = 1'b0;
    rd_addr_d        = {CSR_ADDR_W{1'b0}};
    wr_en_d          = 1'b0;
    wr_addr_d        = {CSR_ADDR_W{1'b0}};
    wr_data_d        = {CSR_DATA_W{1'b0}};
    case (state_d)
      ST_IDLE: cmd_ready_d = 1'b1;
      ST_READ: begin
        rd_en_d   = 1'b1;
        rd_addr_d = addr_d;
      end
      ST_WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_d;
        wr_data_d = new_value_s;
      end
      ST_DONE: begin
        result_valid_d   = 1'b1;
        result_illegal_d = illegal_d;
        if (illegal_d) begin
          result_data_d = {CSR_DATA_W{1'b0}};
        end else begin
          result_data_d = old_d;
        end
      end
      default: cmd_ready_d = 1'b0;
    endcase
  end

  // State, request and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      op_q             <= CSR_OP_RESERVED;
      addr_q           <= {CSR_ADDR_W{1'b0}};
      operand_q        <= {CSR_DATA_W{1'b0}};
      suppress_q       <= 1'b0;
      old_q            <= {CSR_DATA_W{1'b0}};
      illegal_q        <= 1'b0;
      cmd_ready_q      <= 1'b1;
      result_valid_q   <= 1'b0;
      result_data_q    <= {CSR_DATA_W{1'b0}};
      result_illegal_q <= 1'b0;
      rd_en_q          <= 1'b0;
      rd_addr_q        <= {CSR_ADDR_W{1'b0}};
      wr_en_q          <= 1'b0;
      wr_addr_q        <= {CSR_ADDR_W{1'b0}};
      wr_data_q        <= {CSR_DATA_W{1'b0}};
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      addr_q           <= addr_d;
      operand_q        <= operand_d;
      suppress_q       <= suppress_d;
      old_q            <= old_d;
      illegal_q        <= illegal_d;
      cmd_ready_q      <= cmd_ready_d;
      result_valid_q   <= result_valid_d;
      result_data_q    <= result_data_d;
      result_illegal_q <= result_illegal_d;
      rd_en_q          <= rd_en_d;
      rd_addr_q        <= rd_addr_d;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
    end
  end

  assign bus.cmdReady        = cmd_ready_q;
  assign bus.resultValid     = result_valid_q;
  assign bus.resultData      = result_data_q;
  assign bus.resultIllegal   = result_illegal_q;
  assign bus.csrReadEnable   = rd_en_q;
  assign bus.csrReadAddress  = rd_addr_q;
  assign bus.csrWriteEnable  = wr_en_q;
  assign bus.csrWriteAddress = wr_addr_q;
  assign bus.csrWriteData    = wr_data_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: table of CSR requests against a one-register
// responder, scoreboard of expected completions, and hand sequences for
// flush, back-to-back acceptance and reset in the middle of a request.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_access_unit_if bus();

  csr_access_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Single-register responder
  logic [11:0] resp_addr = 12'h000;
  logic        resp_hit  = 1'b0;
  logic [31:0] resp_val;
  logic        resp_load = 1'b0;
  logic [31:0] resp_load_val = 32'h0;

  always_comb begin
    bus.csrRequestOutput = 1'b0;
    bus.csrReadData      = 32'h0;
    if (bus.csrReadEnable && resp_hit && (bus.csrReadAddress == resp_addr)) begin
      bus.csrRequestOutput = 1'b1;
      bus.csrReadData      = resp_val;
    end
  end

  always @(posedge clk) begin
    if (resp_load) resp_val <= resp_load_val;
    else if (bus.csrWriteEnable && resp_hit && (bus.csrWriteAddress == resp_addr))
      resp_val <= bus.csrWriteData;
  end

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        ill;
    int          nwr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] operand;
    logic        sup;
    logic        hit;
    logic [31:0] old;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Bus invariants every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_excl", {31'b0, bus.csrReadEnable & bus.csrWriteEnable}, 32'h0);
      if (!bus.csrReadEnable) chk("rd_addr_idle", {20'b0, bus.csrReadAddress}, 32'h0);
      if (!bus.csrWriteEnable) chk("wr_idle", {20'b0, bus.csrWriteAddress} | bus.csrWriteData, 32'h0);
    end
  end

  task automatic add_vec(input string name, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] operand, input logic sup, input logic hit,
                         input logic [31:0] old, input int lat, input logic [31:0] data,
                         input logic ill, input int nwr, input logic [31:0] wdata);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.operand = operand; v.sup = sup;
    v.hit = hit; v.old = old;
    v.e.lat = lat; v.e.data = data; v.e.ill = ill; v.e.nwr = nwr; v.e.wdata = wdata;
    vecs.push_back(v);
  endtask

  task automatic set_resp(input logic [11:0] addr, input logic hit, input logic [31:0] val);
    resp_addr     = addr;
    resp_hit      = hit;
    resp_load_val = val;
    resp_load     = 1'b1;
    @(negedge clk);
    resp_load     = 1'b0;
  endtask

  // Present one request; returns at the negedge of the first cycle after acceptance
  task automatic drive_cmd(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] operand, input logic sup);
    int w = 0;
    while (!bus.cmdReady && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_issue", {31'b0, bus.cmdReady}, 32'h1);
    bus.cmdValid         = 1'b1;
    bus.cmdOp            = op;
    bus.cmdAddress       = addr;
    bus.cmdOperand       = operand;
    bus.cmdWriteSuppress = sup;
    @(negedge clk);
    bus.cmdValid         = 1'b0;
    bus.cmdOp            = 2'b00;
    bus.cmdAddress       = 12'h000;
    bus.cmdOperand       = 32'h0;
    bus.cmdWriteSuppress = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] operand, input logic sup, input exp_t e);
    sb_q.push_back(e);
    drive_cmd(op, addr, operand, sup);
  endtask

  // Watch cycles k0.. for the completion pulse and any writes, then score it
  task automatic wait_result(input string name, input int k0);
    bit          got = 1'b0;
    int          nwr = 0;
    logic [31:0] wd  = 32'h0;
    int          k   = k0;
    exp_t        e;
    while (!got && k <= 8) begin
      if (bus.csrWriteEnable) begin
        nwr++;
        wd = bus.csrWriteData;
      end
      if (bus.resultValid) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_sb actual=empty expected=entry", name);
      return;
    end
    e = sb_q.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_resultValid expected=resultValid", name);
    end else begin
      chk({name, "_lat"},   k,                      e.lat);
      chk({name, "_data"},  bus.resultData,         e.data);
      chk({name, "_ill"},   {31'b0, bus.resultIllegal}, {31'b0, e.ill});
      chk({name, "_nwr"},   nwr,                    e.nwr);
      if (e.nwr > 0) chk({name, "_wdata"}, wd, e.wdata);
      @(negedge clk);
      chk({name, "_pulse"}, {31'b0, bus.resultValid}, 32'h0);
    end
  endtask

  initial begin
    bit seen_rv;
    bit seen_wr;
    bus.cmdValid = 1'b0; bus.cmdOp = 2'b00; bus.cmdAddress = 12'h000;
    bus.cmdOperand = 32'h0; bus.cmdWriteSuppress = 1'b0; bus.cmdFlush = 1'b0;

    add_vec("rw_340",      2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 1'b1, 32'h12345678, 3, 32'h12345678, 1'b0, 1, 32'hDEADBEEF);
    add_vec("rs_set",      2'b10, 12'h300, 32'h00000008, 1'b0, 1'b1, 32'h00000001, 3, 32'h00000001, 1'b0, 1, 32'h00000009);
    add_vec("rs_sup",      2'b10, 12'h300, 32'h00000008, 1'b1, 1'b1, 32'h00000001, 2, 32'h00000001, 1'b0, 0, 32'h0);
    add_vec("rc_clr",      2'b11, 12'h304, 32'h000000FF, 1'b0, 1'b1, 32'h00001234, 3, 32'h00001234, 1'b0, 1, 32'h00001200);
    add_vec("rw_unimpl",   2'b01, 12'h7C0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        2, 32'h0,        1'b1, 0, 32'h0);
    add_vec("reserved",    2'b00, 12'h340, 32'h00000005, 1'b0, 1'b1, 32'h0000AAAA, 1, 32'h0,        1'b1, 0, 32'h0);
    add_vec("rw_sup",      2'b01, 12'h340, 32'h00000005, 1'b1, 1'b1, 32'h00000007, 3, 32'h00000007, 1'b0, 1, 32'h00000005);
    add_vec("rc_sup",      2'b11, 12'h304, 32'h000000FF, 1'b1, 1'b1, 32'h00001234, 2, 32'h00001234, 1'b0, 0, 32'h0);
`ifdef CSR_READONLY_CHECK_EN
    add_vec("rw_c00",      2'b01, 12'hC00, 32'h000055AA, 1'b0, 1'b1, 32'h00000099, 2, 32'h0,        1'b1, 0, 32'h0);
`else
    add_vec("rw_c00",      2'b01, 12'hC00, 32'h000055AA, 1'b0, 1'b1, 32'h00000099, 3, 32'h00000099, 1'b0, 1, 32'h000055AA);
`endif
    add_vec("rs_c00_sup",  2'b10, 12'hC00, 32'h00000000, 1'b1, 1'b1, 32'h0000ABCD, 2, 32'h0000ABCD, 1'b0, 0, 32'h0);
    add_vec("rs_unimpl",   2'b10, 12'h7C0, 32'h00000000, 1'b1, 1'b0, 32'h0,        2, 32'h0,        1'b1, 0, 32'h0);

    // Reset state
    #12;
    chk("rst_ready",  {31'b0, bus.cmdReady}, 32'h1);
    chk("rst_rvalid", {31'b0, bus.resultValid}, 32'h0);
    chk("rst_ill",    {31'b0, bus.resultIllegal}, 32'h0);
    chk("rst_rdata",  bus.resultData, 32'h0);
    chk("rst_strobes", {30'b0, bus.csrReadEnable, bus.csrWriteEnable}, 32'h0);
    chk("rst_bus",    {20'b0, bus.csrReadAddress} | {20'b0, bus.csrWriteAddress} | bus.csrWriteData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven requests
    foreach (vecs[i]) begin
      set_resp(vecs[i].addr, vecs[i].hit, vecs[i].old);
      issue(vecs[i].op, vecs[i].addr, vecs[i].operand, vecs[i].sup, vecs[i].e);
      wait_result(vecs[i].name, 1);
    end

    // Flush during READ: no write, no completion, ready next cycle
    set_resp(12'h340, 1'b1, 32'h00001111);
    drive_cmd(2'b01, 12'h340, 32'hCAFEF00D, 1'b0);
    chk("flush_in_read", {31'b0, bus.csrReadEnable}, 32'h1);
    bus.cmdFlush = 1'b1;
    @(negedge clk);
    bus.cmdFlush = 1'b0;
    chk("flush_ready", {31'b0, bus.cmdReady}, 32'h1);
    seen_rv = 1'b0;
    seen_wr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen_rv |= bus.resultValid;
      seen_wr |= bus.csrWriteEnable;
      @(negedge clk);
    end
    chk("flush_no_result", {30'b0, seen_rv, seen_wr}, 32'h0);
    chk("flush_csr_kept", resp_val, 32'h00001111);

    // Flush during WRITE is ignored
    begin
      exp_t e;
      e.lat = 3; e.data = 32'h00001111; e.ill = 1'b0; e.nwr = 1; e.wdata = 32'h0F0F0F0F;
      issue(2'b01, 12'h340, 32'h0F0F0F0F, 1'b0, e);
      @(negedge clk);
      bus.cmdFlush = 1'b1;
      wait_result("flush_in_write", 2);
      bus.cmdFlush = 1'b0;
      chk("flush_write_done", resp_val, 32'h0F0F0F0F);
    end

    // Request held through DONE is taken only in the following IDLE cycle
    @(negedge clk);
    bus.cmdValid = 1'b1;
    bus.cmdOp    = 2'b00;
    @(negedge clk);
    chk("b2b_first", {30'b0, bus.resultValid, bus.cmdReady}, 32'h2);
    @(negedge clk);
    chk("b2b_gap",   {30'b0, bus.resultValid, bus.cmdReady}, 32'h1);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    chk("b2b_second", {30'b0, bus.resultValid, bus.cmdReady}, 32'h2);
    @(negedge clk);
    chk("b2b_idle",  {30'b0, bus.resultValid, bus.cmdReady}, 32'h1);

    // Reset during WRITE drops strobes immediately and kills the request
    set_resp(12'h340, 1'b1, 32'h00002222);
    drive_cmd(2'b01, 12'h340, 32'h77777777, 1'b0);
    @(negedge clk);
    chk("rstw_in_write", {31'b0, bus.csrWriteEnable}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_strobes", {30'b0, bus.csrReadEnable, bus.csrWriteEnable}, 32'h0);
    chk("rstw_wdata",   bus.csrWriteData, 32'h0);
    chk("rstw_ready",   {31'b0, bus.cmdReady}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_rv = 1'b0;
    seen_wr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen_rv |= bus.resultValid;
      seen_wr |= bus.csrWriteEnable | bus.csrReadEnable;
      @(negedge clk);
    end
    chk("rstw_quiet", {30'b0, seen_rv, seen_wr}, 32'h0);
    chk("rstw_csr_kept", resp_val, 32'h00002222);

    // Unit still works after the mid-request reset
    begin
      exp_t e;
      e.lat = 3; e.data = 32'h00002222; e.ill = 1'b0; e.nwr = 1; e.wdata = 32'h00002A2A;
      issue(2'b10, 12'h340, 32'h00000808, 1'b0, e);
      wait_result("after_reset", 1);
    end

    chk("sb_drained", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
